// File: rtl/axis_tg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axis_tg_pkg : shared types, LFSR polynomial and step function        |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package axis_tg_pkg;

    typedef enum logic [1:0] {
        UNIFORM    = 2'd0,
        NEIGHBOR   = 2'd1,
        HOTSPOT    = 2'd2,
        COMPLEMENT = 2'd3
    } tg_mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } tg_state_e;

    localparam logic [15:0] LFSR_POLY = 16'hB400;

    // Right-shifting Galois step; feedback taps applied when the output bit is 1
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_tg_pattern_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axis_tg_pattern_if : AXI-Stream link between generator and sink      |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
interface axis_tg_pattern_if #(
    parameter int TDATA_WIDTH = 64,
    parameter int TID_WIDTH   = 2,
    parameter int TDEST_WIDTH = 2
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tlast;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;

    modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
    modport slave  (input tvalid, tdata, tlast, tid, tdest, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_tg_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axis_tg_lfsr : seeded 16-bit Galois LFSR with enable                 |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module axis_tg_lfsr
    import axis_tg_pkg::*;
#(
    parameter logic [15:0] SEED = 16'd1
) (
    input  wire         clk,
    input  wire         rst_n,
    input  wire         en_i,
    output logic [15:0] lfsr_o
);
    // An all-zero state would lock the register up
    localparam logic [15:0] C_SEED = (SEED == 16'd0) ? 16'd1 : SEED;

    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (!rst_n)    lfsr_q <= C_SEED;
        else if (en_i) lfsr_q <= lfsr_next(lfsr_q);
    end

    assign lfsr_o = lfsr_q;
endmodule
`default_nettype wire

// File: rtl/axis_tg_pattern.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axis_tg_pattern : multi-flit AXI-Stream NoC traffic generator        |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module axis_tg_pattern
    import axis_tg_pkg::*;
#(
    parameter int          TDATA_WIDTH = 64,
    parameter int          TDEST_WIDTH = 2,
    parameter int          TID_WIDTH   = 2,
    parameter int          NUM_ROUTERS = 4,
    parameter int          COUNT_WIDTH = 32,
    parameter int          TID         = 0,
    parameter logic [15:0] SEED        = 16'd1,
    parameter int          MAX_FLITS   = 8,
    parameter int          FLIT_CNT_W  = $clog2(MAX_FLITS + 1)
) (
    input  wire                                    clk,
    input  wire                                    rst_n,
    input  wire                                    start,
    input  wire  [1:0]                             mode,
    input  wire  [15:0]                            load,
    input  wire  [COUNT_WIDTH-1:0]                 num_packets,
    input  wire  [FLIT_CNT_W-1:0]                  pkt_flits,
    input  wire  [TDEST_WIDTH-1:0]                 hotspot_dest,
    input  wire  [31:0]                            ticks,
    output logic                                   done,
    output logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] sent_packets,
    output logic [COUNT_WIDTH-1:0]                 total_sent_packets,
    axis_tg_pattern_if.master                      axis_out
);
    localparam int C_HALF_W = TDATA_WIDTH / 2;
    localparam int C_SEQ_W  = C_HALF_W - 8;

    tg_state_e                             state_q, state_d;
    logic                                  tvalid_q, tvalid_d;
    logic [FLIT_CNT_W-1:0]                 idx_q, idx_d, len_q, len_d;
    logic [TDEST_WIDTH-1:0]                dest_q, dest_d;
    logic [TID_WIDTH-1:0]                  tid_q, tid_d;
    logic [31:0]                           ticks_q, ticks_d;
    logic [COUNT_WIDTH-1:0]                seq_q, seq_d, total_q, total_d;
    logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [15:0]             w_lfsr;
    logic                    w_last, w_hs_last, w_inject, start_pkt;
    logic [COUNT_WIDTH-1:0]  w_tot_after;
    logic [FLIT_CNT_W-1:0]   w_len;
    logic [TDEST_WIDTH-1:0]  w_dest;

    axis_tg_lfsr #(.SEED(SEED)) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (1'b1),
        .lfsr_o (w_lfsr)
    );

    assign w_last      = (idx_q == len_q - FLIT_CNT_W'(1));
    assign w_hs_last   = tvalid_q && axis_out.tready && w_last;
    assign w_tot_after = total_q + COUNT_WIDTH'(w_hs_last);
    assign w_inject    = start && (w_lfsr < load);

    always_comb begin
        if (pkt_flits == '0)                  w_len = FLIT_CNT_W'(1);
        else if (int'(pkt_flits) > MAX_FLITS) w_len = FLIT_CNT_W'(MAX_FLITS);
        else                                  w_len = pkt_flits;
    end

    always_comb begin
        w_dest = '0;
        case (tg_mode_e'(mode))
            UNIFORM:    w_dest = (int'(w_lfsr[TDEST_WIDTH-1:0]) >= NUM_ROUTERS)
                               ? TDEST_WIDTH'(int'(w_lfsr[TDEST_WIDTH-1:0]) - NUM_ROUTERS)
                               : w_lfsr[TDEST_WIDTH-1:0];
            NEIGHBOR:   w_dest = TDEST_WIDTH'((TID + 1) % NUM_ROUTERS);
            HOTSPOT:    w_dest = (int'(hotspot_dest) >= NUM_ROUTERS) ? '0 : hotspot_dest;
            COMPLEMENT: w_dest = TDEST_WIDTH'(NUM_ROUTERS - 1 - TID);
            default:    w_dest = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        tvalid_d  = tvalid_q;
        idx_d     = idx_q;
        len_d     = len_q;
        dest_d    = dest_q;
        tid_d     = tid_q;
        ticks_d   = ticks_q;
        seq_d     = seq_q;
        total_d   = w_tot_after;
        cnt_d     = cnt_q;
        start_pkt = 1'b0;
        if (w_hs_last) cnt_d[dest_q] = cnt_q[dest_q] + COUNT_WIDTH'(1);

        case (state_q)
            S_IDLE: if (start) state_d = S_GAP;
            S_GAP: begin
                if (w_tot_after == num_packets) state_d = S_DONE;
                else if (!start)                state_d = S_IDLE;
                else if (w_inject)              start_pkt = 1'b1;
            end
            S_SEND: begin
                if (axis_out.tready) begin
                    if (!w_last) begin
                        idx_d = idx_q + FLIT_CNT_W'(1);
                    end else begin
                        // The tlast handshake doubles as an inject slot for back-to-back packets
                        tvalid_d = 1'b0;
                        if (w_tot_after == num_packets) state_d = S_DONE;
                        else if (!start)                state_d = S_IDLE;
                        else if (w_inject)              start_pkt = 1'b1;
                        else                            state_d = S_GAP;
                    end
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        if (start_pkt) begin
            state_d  = S_SEND;
            tvalid_d = 1'b1;
            idx_d    = '0;
            len_d    = w_len;
            dest_d   = w_dest;
            tid_d    = TID_WIDTH'(TID);
            ticks_d  = ticks;
            seq_d    = w_tot_after;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tvalid_q <= 1'b0;
            idx_q    <= '0;
            len_q    <= '0;
            dest_q   <= '0;
            tid_q    <= '0;
            ticks_q  <= '0;
            seq_q    <= '0;
            total_q  <= '0;
            cnt_q    <= '0;
        end else begin
            tvalid_q <= tvalid_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            dest_q   <= dest_d;
            tid_q    <= tid_d;
            ticks_q  <= ticks_d;
            seq_q    <= seq_d;
            total_q  <= total_d;
            cnt_q    <= cnt_d;
        end
    end

    assign done               = (state_q == S_DONE);
    assign sent_packets       = cnt_q;
    assign total_sent_packets = total_q;
    assign axis_out.tvalid    = tvalid_q;
    assign axis_out.tlast     = tvalid_q && w_last;
    assign axis_out.tid       = tid_q;
    assign axis_out.tdest     = dest_q;
    assign axis_out.tdata     = {C_HALF_W'(ticks_q), C_SEQ_W'(seq_q), 8'(idx_q)};
endmodule
`default_nettype wire

// File: tb/tb_axis_tg_pattern.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_axis_tg_pattern : randomized bench with a packet-level model      |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_axis_tg_pattern;
    localparam int NR   = 4;
    localparam int TIDV = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [1:0]       mode;
    logic [15:0]      load;
    logic [31:0]      num_packets;
    logic [3:0]       pkt_flits;
    logic [1:0]       hotspot_dest;
    logic [31:0]      ticks;
    logic             done;
    logic [3:0][31:0] sent_packets;
    logic [31:0]      total_sent_packets;

    axis_tg_pattern_if #(.TDATA_WIDTH(64), .TID_WIDTH(2), .TDEST_WIDTH(2)) axis_out ();

    axis_tg_pattern #(
        .TDATA_WIDTH(64), .TDEST_WIDTH(2), .TID_WIDTH(2), .NUM_ROUTERS(NR),
        .COUNT_WIDTH(32), .TID(TIDV), .SEED(16'd1), .MAX_FLITS(8), .FLIT_CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .load(load),
        .num_packets(num_packets), .pkt_flits(pkt_flits), .hotspot_dest(hotspot_dest),
        .ticks(ticks), .done(done), .sent_packets(sent_packets),
        .total_sent_packets(total_sent_packets), .axis_out(axis_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: packet-level view of the generator
    bit          m_valid, m_armed, m_done;
    logic [7:0]  m_idx, m_len;
    logic [31:0] m_seq, m_total, m_ticks;
    logic [31:0] m_cnt [NR];
    logic [1:0]  m_dest;
    logic [15:0] m_lfsr;

    bit stat_en, saw_valid;
    int st_cycles, st_valid, n_hs;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_dest(input logic [1:0] md, input logic [15:0] lf,
                                            input logic [1:0] hs);
        int d;
        case (md)
            2'd0:    begin d = int'(lf & 16'h3); if (d >= NR) d = d - NR; end
            2'd1:    d = (TIDV + 1) % NR;
            2'd2:    d = (int'(hs) >= NR) ? 0 : int'(hs);
            default: d = NR - 1 - TIDV;
        endcase
        return 2'(d);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_armed = 0; m_done = 0;
        m_idx = 0; m_len = 0; m_seq = 0; m_total = 0; m_ticks = 0; m_dest = 0;
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        m_lfsr = 16'd1;
    endtask

    task automatic model_step();
        bit hs, last;
        if (!rst_n) begin
            model_reset();
            return;
        end
        hs   = m_valid && axis_out.tready;
        last = hs && (m_idx == m_len - 8'd1);
        if (last) begin
            m_total = m_total + 1;
            m_cnt[m_dest] = m_cnt[m_dest] + 1;
        end else if (hs) begin
            m_idx = m_idx + 8'd1;
        end
        if (!m_valid || last) begin
            m_valid = 0;
            if (!m_done) begin
                if (m_armed) begin
                    if (m_total == num_packets) begin
                        m_done = 1; m_armed = 0;
                    end else if (!start) begin
                        m_armed = 0;
                    end else if (m_lfsr < load) begin
                        m_valid = 1;
                        m_idx   = 0;
                        m_len   = (pkt_flits == 0) ? 8'd1 : (pkt_flits > 8) ? 8'd8 : 8'(pkt_flits);
                        m_dest  = ref_dest(mode, m_lfsr, hotspot_dest);
                        m_seq   = m_total;
                        m_ticks = ticks;
                    end
                end else if (start) begin
                    m_armed = 1;
                end
            end
        end
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    endtask

    task automatic compare_all();
        check("tvalid", 64'(axis_out.tvalid), 64'(m_valid));
        check("done", 64'(done), 64'(m_done));
        check("total", 64'(total_sent_packets), 64'(m_total));
        for (int i = 0; i < NR; i++) check("sent_packets", 64'(sent_packets[i]), 64'(m_cnt[i]));
        if (m_valid) begin
            check("tdata", axis_out.tdata, {m_ticks, m_seq[23:0], m_idx});
            check("tdest", 64'(axis_out.tdest), 64'(m_dest));
            check("tlast", 64'(axis_out.tlast), 64'(m_idx == m_len - 8'd1));
            check("tid", 64'(axis_out.tid), 64'(TIDV));
        end
        saw_valid = saw_valid | axis_out.tvalid;
        if (stat_en && !m_done) begin
            st_cycles++;
            if (axis_out.tvalid) st_valid++;
        end
    endtask

    task automatic tick();
        if (axis_out.tvalid && axis_out.tready) n_hs++;
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input int ready_pct, input bit rnd_ctl);
        ticks = $urandom;
        axis_out.tready = ($urandom_range(0, 99) < ready_pct);
        if (rnd_ctl) begin
            mode         = 2'($urandom_range(0, 3));
            pkt_flits    = 4'($urandom_range(0, 15));
            hotspot_dest = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic run(input int n, input int ready_pct, input bit rnd_ctl);
        for (int i = 0; i < n; i++) begin
            drive(ready_pct, rnd_ctl);
            tick();
        end
    endtask

    task automatic run_until_done(input string tag, input int budget, input int ready_pct);
        bit fin = 0;
        for (int i = 0; i < budget && !fin; i++) begin
            drive(ready_pct, 1'b0);
            tick();
            fin = done;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_idx(input string tag, input logic [7:0] idx);
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            drive(100, 1'b0);
            tick();
            found = axis_out.tvalid && (axis_out.tdata[7:0] == idx);
        end
        check(tag, 64'(found), 64'd1);
    endtask

    initial begin
        logic [31:0] seq_drop, sum;
        rst_n = 1'b0; start = 1'b0; mode = 2'd1; load = 16'hFFFF; num_packets = 32'd4;
        pkt_flits = 4'd3; hotspot_dest = 2'd0; ticks = 32'd0; axis_out.tready = 1'b1;
        model_reset();
        do_reset();
        check("rst_tdata", axis_out.tdata, 64'd0);
        check("rst_tdest", 64'(axis_out.tdest), 64'd0);
        check("rst_tid", 64'(axis_out.tid), 64'd0);
        check("rst_tlast", 64'(axis_out.tlast), 64'd0);

        // Neighbor mode, 4 x 3-flit packets back to back
        start = 1'b1; n_hs = 0;
        run_until_done("p1_done", 100, 100);
        check("p1_flits", 64'(n_hs), 64'd12);
        check("p1_sent3", 64'(sent_packets[3]), 64'd4);
        check("p1_total", 64'(total_sent_packets), 64'd4);

        // Zero load never injects
        do_reset();
        load = 16'h0; num_packets = 32'd10; start = 1'b1; saw_valid = 0;
        run(1000, 100, 1'b0);
        check("p2_no_valid", 64'(saw_valid), 64'd0);
        check("p2_done", 64'(done), 64'd0);

        // Uniform mode statistics
        do_reset();
        mode = 2'd0; load = 16'h8000; num_packets = 32'd4096; pkt_flits = 4'd1; start = 1'b1;
        stat_en = 1; st_cycles = 0; st_valid = 0;
        run_until_done("p3_done", 12000, 100);
        stat_en = 0;
        sum = 0;
        for (int i = 0; i < NR; i++) begin
            sum = sum + sent_packets[i];
            check("p3_dest_spread", 64'(sent_packets[i] >= 874 && sent_packets[i] <= 1174), 64'd1);
        end
        check("p3_sum", 64'(sum), 64'd4096);
        check("p3_duty", 64'(st_valid * 1000 >= st_cycles * 450 && st_valid * 1000 <= st_cycles * 550), 64'd1);

        // Backpressure with 5-flit packets
        do_reset();
        mode = 2'($urandom_range(0, 3)); hotspot_dest = 2'($urandom_range(0, 3));
        load = 16'($urandom_range(16'h2000, 16'hFFFF)); num_packets = 32'd25; pkt_flits = 4'd5;
        start = 1'b1;
        run_until_done("p4_done", 4000, 50);

        // start dropped during flit 1 of 4
        do_reset();
        mode = 2'd1; load = 16'hFFFF; num_packets = 32'd100; pkt_flits = 4'd4; start = 1'b1;
        wait_idx("p5_wait_flit1", 8'd1);
        seq_drop = m_seq;
        start = 1'b0;
        run(12, 100, 1'b0);
        check("p5_held_total", 64'(total_sent_packets), 64'(seq_drop + 1));
        check("p5_idle", 64'(axis_out.tvalid), 64'd0);
        start = 1'b1;
        run(30, 100, 1'b0);

        // Reset mid-packet
        wait_idx("p6_wait_flit2", 8'd2);
        rst_n = 1'b0;
        tick();
        check("p6_rst_valid", 64'(axis_out.tvalid), 64'd0);
        check("p6_rst_total", 64'(total_sent_packets), 64'd0);
        rst_n = 1'b1;

        // Randomized controls changing under packets in flight, then length boundaries
        do_reset();
        load = 16'hC000; num_packets = 32'd1000; start = 1'b1;
        run(300, 70, 1'b1);
        pkt_flits = 4'd0;
        run(60, 100, 1'b0);
        pkt_flits = 4'd15;
        run(80, 60, 1'b0);

        // num_packets = 0 goes straight to done
        do_reset();
        num_packets = 32'd0; start = 1'b1;
        run(4, 100, 1'b0);
        check("p8_done", 64'(done), 64'd1);
        check("p8_total", 64'(total_sent_packets), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
